mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline register for the segmented processor, successor to the fixed 32-bit MEM-stage latch. It captures the execute result, memory read data and destination register at the end of the memory stage and presents a single registered write-back value to the register file. Adds valid tracking, stall/flush control, write-enable gating for register 0, an optional load-extension unit, and a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 14 +
 rtl/mem_wb_stage_load_extend.sv | 38 +++
 rtl/mem_wb_stage.sv | 96 +++++++++
 tb/tb_mem_wb_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline register: load-size encodings
// and default datapath widths.
package mem_wb_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CNT_W  = 32;

  // 2'b11 is also treated as a word load.
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load-extension unit: little-endian byte/half lane select with
// sign or zero extension. Used by mem_wb_stage only when MEMWB_LOAD_EXT_EN is defined.
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] mem_in,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [1:0]  addr_lo,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  // NOTE: every signal written in an always_comb gets a default first so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    byte_sel = mem_in[{addr_lo, 3'b000} +: 8];
    half_sel = mem_in[{addr_lo[1], 4'b0000} +: 16];
    fill     = 1'b0;
    value    = mem_in;
    case (size)
      LD_BYTE: begin
        fill  = ~ld_unsigned & byte_sel[7];
        value = {{24{fill}}, byte_sel};
      end
      LD_HALF: begin
        fill  = ~ld_unsigned & half_sel[15];
        value = {{16{fill}}, half_sel};
      end
      LD_WORD: value = mem_in;
      default: value = mem_in;
    endcase
  end

endmodule : load_extend

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid tracking, stall/flush, r0 write gating and
// a retired-instruction counter. Define MEMWB_LOAD_EXT_EN for sub-word load extension.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              reg_we_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        ld_size_in,
  input  logic              ld_unsigned_in,
  input  logic [1:0]        addr_lo_in,
  output logic              valid_out,
  output logic              reg_we_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [DATA_W-1:0] load_value;

`ifdef MEMWB_LOAD_EXT_EN
  // Extension unit is 32-bit only; DATA_W must be 32 in this build.
  load_extend u_load_extend (
    .mem_in      (mem_in),
    .size        (ld_size_in),
    .ld_unsigned (ld_unsigned_in),
    .addr_lo     (addr_lo_in),
    .value       (load_value)
  );
`else
  logic unused_ld_ctrl;
  assign unused_ld_ctrl = ^{ld_size_in, ld_unsigned_in, addr_lo_in};
  assign load_value     = mem_in;
`endif

  logic              valid_q, valid_d;
  logic              we_q,    we_d;
  logic [REG_W-1:0]  rd_q,    rd_d;
  logic [DATA_W-1:0] wb_q,    wb_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Flush beats stall; stall holds everything; reset is applied in the flop block.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall) begin
      valid_d = valid_in;
      we_d    = reg_we_in & valid_in & (rd_in != '0);
      rd_d    = rd_in;
      wb_d    = mem_to_reg_in ? load_value : alu_in;
      cnt_d   = cnt_q + CNT_W'(valid_in);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out   = valid_q;
  assign reg_we_out  = we_q;
  assign rd_out      = rd_q;
  assign wb_data_out = wb_q;
  assign retired_cnt = cnt_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second instance with CNT_W=4
// exercises counter wrap. Load-extension vectors follow MEMWB_LOAD_EXT_EN.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, reg_we_in, mem_to_reg_in;
  logic [31:0] alu_in, mem_in;
  logic [4:0]  rd_in;
  logic [1:0]  ld_size_in, addr_lo_in;
  logic        ld_unsigned_in;

  logic        valid_out, reg_we_out, valid_out4, reg_we_out4;
  logic [4:0]  rd_out, rd_out4;
  logic [31:0] wb_data_out, wb_data_out4, retired_cnt;
  logic [3:0]  retired_cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_we_in(reg_we_in), .mem_to_reg_in(mem_to_reg_in), .alu_in(alu_in),
    .mem_in(mem_in), .rd_in(rd_in), .ld_size_in(ld_size_in),
    .ld_unsigned_in(ld_unsigned_in), .addr_lo_in(addr_lo_in),
    .valid_out(valid_out), .reg_we_out(reg_we_out), .rd_out(rd_out),
    .wb_data_out(wb_data_out), .retired_cnt(retired_cnt)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_we_in(reg_we_in), .mem_to_reg_in(mem_to_reg_in), .alu_in(alu_in),
    .mem_in(mem_in), .rd_in(rd_in), .ld_size_in(ld_size_in),
    .ld_unsigned_in(ld_unsigned_in), .addr_lo_in(addr_lo_in),
    .valid_out(valid_out4), .reg_we_out(reg_we_out4), .rd_out(rd_out4),
    .wb_data_out(wb_data_out4), .retired_cnt(retired_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and track the expected retired count.
  task automatic step();
    if (rst)                          exp_cnt = 0;
    else if (!flush && !stall && valid_in) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic we,
                            input logic [4:0] rd, input logic [31:0] wb);
    check({tag, ".valid"}, 64'(valid_out), 64'(v));
    check({tag, ".we"},    64'(reg_we_out), 64'(we));
    check({tag, ".rd"},    64'(rd_out), 64'(rd));
    check({tag, ".wb"},    64'(wb_data_out), 64'(wb));
    check({tag, ".cnt"},   64'(retired_cnt), 64'(exp_cnt));
    check({tag, ".cnt4"},  64'(retired_cnt4), 64'(exp_cnt % 16));
  endtask

  task automatic drive(input logic v, input logic we, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
    valid_in = v; reg_we_in = we; mem_to_reg_in = m2r;
    rd_in = rd; alu_in = alu; mem_in = mem;
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                      input logic [31:0] exp_ext, input string tag);
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0BAD_0BAD, 32'h80FF_7F01);
    ld_size_in = sz; ld_unsigned_in = uns; addr_lo_in = lo;
    step();
`ifdef MEMWB_LOAD_EXT_EN
    check(tag, 64'(wb_data_out), 64'(exp_ext));
`else
    check(tag, 64'(wb_data_out), 64'h80FF_7F01);
    if (exp_ext == 32'h0) $display("unexpected zero vector");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ld_size_in = 2'b10; ld_unsigned_in = 1'b0; addr_lo_in = 2'b00;
    step();
    rst = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 5'd0, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    check_outs("alu_rd5", 1'b1, 1'b1, 5'd5, 32'h1234_5678);
    check("alu_rd5.cnt1", 64'(retired_cnt), 64'd1);

    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    step();
    check_outs("rd0_gate", 1'b1, 1'b0, 5'd0, 32'hCAFE_F00D);

    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_0011, 32'hDEAD_BEEF);
    step();
    check_outs("invalid", 1'b0, 1'b0, 5'd7, 32'h0000_0011);

    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h5555_5555, 32'h80FF_7F01);
    step();
    check_outs("mem_word", 1'b1, 1'b1, 5'd9, 32'h80FF_7F01);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(12 + i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      step();
      check_outs($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd9, 32'h80FF_7F01);
    end
    stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd12, 32'hA5A5_A5A5, 32'h0);
    step();
    check_outs("stall_release", 1'b1, 1'b1, 5'd12, 32'hA5A5_A5A5);

    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h3, 32'h3);
    step();
    check_outs("flush_stall", 1'b0, 1'b0, 5'd12, 32'hA5A5_A5A5);
    flush = 1'b0;

    rst = 1'b1;
    step();
    check_outs("rst_mid_stall", 1'b0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h42, 32'h0);
    step();
    check_outs("post_rst", 1'b1, 1'b1, 5'd1, 32'h42);

    load(2'b00, 1'b0, 2'd3, 32'hFFFF_FF80, "ld_b3_s");
    load(2'b00, 1'b1, 2'd3, 32'h0000_0080, "ld_b3_u");
    load(2'b00, 1'b0, 2'd1, 32'h0000_007F, "ld_b1_s");
    load(2'b00, 1'b0, 2'd2, 32'hFFFF_FFFF, "ld_b2_s");
    load(2'b01, 1'b0, 2'd0, 32'h0000_7F01, "ld_h0_s");
    load(2'b01, 1'b0, 2'd2, 32'hFFFF_80FF, "ld_h1_s");
    load(2'b01, 1'b0, 2'd3, 32'hFFFF_80FF, "ld_h1_odd");
    load(2'b01, 1'b1, 2'd2, 32'h0000_80FF, "ld_h1_u");
    load(2'b11, 1'b0, 2'd3, 32'h80FF_7F01, "ld_w11");

    rst = 1'b1;
    step();
    rst = 1'b0;
    ld_size_in = 2'b10;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(i), 32'h1000 + 32'(i), 32'h0);
      step();
      check_outs($sformatf("wrap%0d", i), 1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i));
    end
    check("wrap.cnt4_final", 64'(retired_cnt4), 64'd1);
    check("wrap.cnt32_final", 64'(retired_cnt), 64'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_wb_stage
